// File: rtl/gcd_ctrl_datapath.sv
// rtl/gcd_ctrl_datapath.sv - 16-bit subtractive GCD engine, controller FSM plus datapath; optional GCD_STATUS_EN exports eq/lt/gt
module gcd_ctrl_datapath (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] data_in,
  output logic        done,
  output logic [15:0] gcd_out,
  output logic [15:0] a_out,
  output logic [15:0] b_out
`ifdef GCD_STATUS_EN
  ,
  output logic        eq,
  output logic        lt,
  output logic        gt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD_B = 2'd1,
    S_CALC   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic [15:0] gcd_q, gcd_d;
  logic        done_q, done_d;

  logic a_eq_b;
  logic a_gt_b;
  logic finish_now;

  assign a_eq_b = (a_q == b_q);
  assign a_gt_b = (a_q > b_q);
  // Either zero operand ends the loop at once, otherwise subtraction would never converge.
  assign finish_now = a_eq_b || (a_q == 16'd0) || (b_q == 16'd0);

  // State and datapath registers, cleared asynchronously from any state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= 16'd0;
      b_q     <= 16'd0;
      gcd_q   <= 16'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      gcd_q   <= gcd_d;
      done_q  <= done_d;
    end
  end

  // Next-state and datapath control: one load or one subtraction per cycle.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    gcd_d   = gcd_q;
    done_d  = done_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = data_in;
          state_d = S_LOAD_B;
        end
      end
      S_LOAD_B: begin
        b_d     = data_in;
        state_d = S_CALC;
      end
      S_CALC: begin
        if (finish_now) begin
          gcd_d   = (b_q == 16'd0) ? a_q : b_q;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else if (a_gt_b) begin
          a_d = a_q - b_q;
        end else begin
          b_d = b_q - a_q;
        end
      end
      S_DONE: begin
        if (start) begin
          a_d     = data_in;
          done_d  = 1'b0;
          state_d = S_LOAD_B;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign done    = done_q;
  assign gcd_out = gcd_q;
  assign a_out   = a_q;
  assign b_out   = b_q;

`ifdef GCD_STATUS_EN
  assign eq = a_eq_b;
  assign lt = (a_q < b_q);
  assign gt = a_gt_b;
`endif

endmodule

// File: tb/tb_gcd_ctrl_datapath.sv
// tb/tb_gcd_ctrl_datapath.sv - scoreboard bench for gcd_ctrl_datapath against a Euclid reference model
module tb_gcd_ctrl_datapath;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] data_in;
  logic        done;
  logic [15:0] gcd_out;
  logic [15:0] a_out;
  logic [15:0] b_out;
`ifdef GCD_STATUS_EN
  logic        eq;
  logic        lt;
  logic        gt;
`endif

  gcd_ctrl_datapath dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .data_in (data_in),
    .done    (done),
    .gcd_out (gcd_out),
    .a_out   (a_out),
    .b_out   (b_out)
`ifdef GCD_STATUS_EN
    ,
    .eq      (eq),
    .lt      (lt),
    .gt      (gt)
`endif
  );

  typedef struct {
    int unsigned g;
    int unsigned fa;
    int unsigned fb;
    int unsigned at;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Euclid with division: gcd, and subtraction count = sum of quotients - 1.
  function automatic void model(input int unsigned a, input int unsigned b,
                                output int unsigned g, output int unsigned n);
    int unsigned x, y, t, q;
    if (a == 0 || b == 0) begin
      g = a + b;
      n = 0;
    end else begin
      x = a; y = b; q = 0;
      while (y != 0) begin
        q += x / y;
        t = x % y;
        x = y;
        y = t;
      end
      g = x;
      n = q - 1;
    end
  endfunction

  function automatic exp_t make_exp(input int unsigned a, input int unsigned b);
    exp_t e;
    int unsigned g, n;
    model(a, b, g, n);
    e.g  = g;
    e.fa = (a == 0 || b == 0) ? a : g;
    e.fb = (a == 0 || b == 0) ? b : g;
    e.at = cyc + 1 + n + 2;
    return e;
  endfunction

  // Monitor: every rising done is one result to compare against the scoreboard head.
  logic done_prev = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (done && !done_prev) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        check("gcd_out", gcd_out, e.g);
        check("latency_cycle", cyc, e.at);
        check("a_final", a_out, e.fa);
        check("b_final", b_out, e.fb);
      end
    end
`ifdef GCD_STATUS_EN
    if (!rst) begin
      check("eq_flag", eq, a_out == b_out);
      check("lt_flag", lt, a_out < b_out);
      check("gt_flag", gt, a_out > b_out);
    end
`endif
    done_prev <= done;
  end

  task automatic issue(input int unsigned a, input int unsigned b);
    @(negedge clk);
    start   = 1'b1;
    data_in = 16'(a);
    sb.push_back(make_exp(a, b));
    @(negedge clk);
    start   = 1'b0;
    data_in = 16'(b);
  endtask

  task automatic wait_all(input int limit);
    for (int i = 0; i < limit; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
    end
    if (sb.size() != 0) begin
      check("timeout_pending", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_done"}, done, 0);
    check({tag, "_gcd"}, gcd_out, 0);
    check({tag, "_a"}, a_out, 0);
    check({tag, "_b"}, b_out, 0);
  endtask

  initial begin
    int unsigned ra, rb;
    bit          seen;
    rst = 1'b1; start = 1'b0; data_in = 16'd0;
    #1;
    check_zero("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    issue(143, 78);  wait_all(200);
    issue(48, 48);   wait_all(200);
    issue(0, 21);    wait_all(200);
    issue(21, 0);    wait_all(200);
    issue(0, 0);     wait_all(200);
    issue(65535, 1); wait_all(70000);

    // start pulses during CALC must be ignored
    issue(200, 3);
    repeat (10) @(negedge clk);
    start = 1'b1; data_in = 16'd7;
    @(negedge clk);
    start = 1'b0;
    wait_all(500);

    // asynchronous reset in the middle of CALC
    issue(300, 7);
    repeat (6) @(negedge clk);
    start = 1'b1; data_in = 16'd5;
    @(negedge clk);
    start = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_zero("midcalc_reset");
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    issue(12, 18); wait_all(200);

    // back-to-back: start held high through CALC and into DONE
    @(negedge clk);
    start = 1'b1; data_in = 16'd100;
    sb.push_back(make_exp(100, 75));
    @(negedge clk);
    data_in = 16'd75;
    seen = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check("b2b_done_seen", seen, 1);
    data_in = 16'd9;
    sb.push_back(make_exp(9, 6));
    @(negedge clk);
    check("b2b_done_one_cycle", done, 0);
    data_in = 16'd6;
    start   = 1'b0;
    wait_all(500);

    // randomized operands, small enough to keep runtime bounded
    for (int k = 0; k < 24; k++) begin
      ra = $urandom_range(0, 255);
      rb = $urandom_range(0, 255);
      if ($urandom_range(0, 7) == 0) ra = 0;
      if ($urandom_range(0, 7) == 0) rb = 0;
      issue(ra, rb);
      wait_all(1000);
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
